// File: rtl/bus_rr_arbiter.sv
// Two-master, three-slave bus arbiter.
// Round-robin choice between the masters, one-hot slave decode of the winner's target,
// ownership held for a whole transaction, and a watchdog that force-releases a stalled owner.
// Every output comes straight from a flop.
module bus_rr_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned CNT_W          = 13
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       m1_request_i,
   input  logic [1:0] m1_slave_select_i,
   input  logic       m1_tx_done_i,
   input  logic       m2_request_i,
   input  logic [1:0] m2_slave_select_i,
   input  logic       m2_tx_done_i,
   output logic       m1_grant_o,
   output logic       m2_grant_o,
   output logic       busy_o,
   output logic [1:0] bus_grant_o,
   output logic [2:0] slave_grant_o,
   output logic       timeout_o,
   output logic       sel_error_o
);

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StBusy,
      StRelease
   } state_e;

   // Last watchdog value allowed in BUSY before the forced release.
   localparam logic [CNT_W-1:0] WdogLast = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q, state_d;
   logic             owner_q, owner_d;       // 0 = M1, 1 = M2
   logic             last_q, last_d;         // master served last, 0 = M1, 1 = M2
   logic [CNT_W-1:0] wdog_q, wdog_d;
   logic [1:0]       grant_q, grant_d;       // {m2, m1}
   logic             busy_q, busy_d;
   logic [2:0]       slave_q, slave_d;
   logic             timeout_q, timeout_d;
   logic             sel_error_q, sel_error_d;

   logic             any_req;
   logic             win_m2;
   logic [1:0]       win_sel;
   logic             owner_req;
   logic             owner_done;

   // Slave code to one-hot select; code 00 selects nothing.
   function automatic logic [2:0] decode_slave(input logic [1:0] code);
      logic [2:0] sel;
      sel = 3'b000;
      unique case (code)
         2'b01:   sel = 3'b001;
         2'b10:   sel = 3'b010;
         2'b11:   sel = 3'b100;
         default: sel = 3'b000;
      endcase
      return sel;
   endfunction

   // Round-robin winner: a tie goes to the master that was not served last.
   always_comb begin
      any_req    = m1_request_i | m2_request_i;
      win_m2     = (m1_request_i & m2_request_i) ? ~last_q : m2_request_i;
      win_sel    = win_m2 ? m2_slave_select_i : m1_slave_select_i;
      owner_req  = owner_q ? m2_request_i : m1_request_i;
      owner_done = owner_q ? m2_tx_done_i : m1_tx_done_i;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      wdog_d      = '0;
      grant_d     = grant_q;
      slave_d     = slave_q;
      timeout_d   = 1'b0;
      sel_error_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            grant_d = 2'b00;
            slave_d = 3'b000;
            if (any_req) begin
               // An invalid target still consumes the winner's turn.
               last_d = win_m2;
               if (win_sel != 2'b00) begin
                  state_d = StGrant;
                  owner_d = win_m2;
                  grant_d = win_m2 ? 2'b10 : 2'b01;
                  slave_d = decode_slave(win_sel);
               end else begin
                  sel_error_d = 1'b1;
               end
            end
         end

         StGrant: begin
            if (owner_req) begin
               state_d = StBusy;
            end else begin
               state_d = StRelease;
               grant_d = 2'b00;
               slave_d = 3'b000;
            end
         end

         StBusy: begin
            if (owner_done) begin
               state_d = StRelease;
               grant_d = 2'b00;
               slave_d = 3'b000;
            end else if (wdog_q == WdogLast) begin
               state_d   = StRelease;
               grant_d   = 2'b00;
               slave_d   = 3'b000;
               timeout_d = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         StRelease: begin
            state_d = StIdle;
            grant_d = 2'b00;
            slave_d = 3'b000;
         end

         default: begin
            state_d = StIdle;
            grant_d = 2'b00;
            slave_d = 3'b000;
         end
      endcase

      busy_d = |grant_d;
   end

   // State and output registers; reset makes M1 win the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         wdog_q      <= '0;
         grant_q     <= 2'b00;
         busy_q      <= 1'b0;
         slave_q     <= 3'b000;
         timeout_q   <= 1'b0;
         sel_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         wdog_q      <= wdog_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         slave_q     <= slave_d;
         timeout_q   <= timeout_d;
         sel_error_q <= sel_error_d;
      end
   end

   assign m1_grant_o    = grant_q[0];
   assign m2_grant_o    = grant_q[1];
   assign busy_o        = busy_q;
   assign bus_grant_o   = grant_q;
   assign slave_grant_o = slave_q;
   assign timeout_o     = timeout_q;
   assign sel_error_o   = sel_error_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: per-cycle stimulus and expected outputs are queued together,
// then each scenario task replays its queue and compares after every clock edge.
module tb_bus_rr_arbiter;

   localparam int unsigned TO = 8;
   localparam int unsigned CW = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       m1_req, m1_done, m2_req, m2_done;
   logic [1:0] m1_sel, m2_sel;
   logic       m1_grant, m2_grant, busy, timeout, sel_error;
   logic [1:0] bus_grant;
   logic [2:0] slave_grant;
   logic [9:0] obs;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0] stim_q[$];
   logic [9:0] exp_q[$];

   localparam logic [9:0] Z = 10'b0;

   always #5 clk = ~clk;

   bus_rr_arbiter #(
      .TIMEOUT_CYCLES(TO),
      .CNT_W         (CW)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .m1_request_i     (m1_req),
      .m1_slave_select_i(m1_sel),
      .m1_tx_done_i     (m1_done),
      .m2_request_i     (m2_req),
      .m2_slave_select_i(m2_sel),
      .m2_tx_done_i     (m2_done),
      .m1_grant_o       (m1_grant),
      .m2_grant_o       (m2_grant),
      .busy_o           (busy),
      .bus_grant_o      (bus_grant),
      .slave_grant_o    (slave_grant),
      .timeout_o        (timeout),
      .sel_error_o      (sel_error)
   );

   assign obs = {m1_grant, m2_grant, busy, bus_grant, slave_grant, timeout, sel_error};

   function automatic logic [7:0] st(input logic r1, input logic [1:0] s1, input logic d1,
                                     input logic r2, input logic [1:0] s2, input logic d2);
      return {r1, s1, d1, r2, s2, d2};
   endfunction

   // Expected output vector; busy and bus_grant follow from the grants by definition.
   function automatic logic [9:0] ex(input logic g1, input logic g2, input logic [2:0] sg,
                                     input logic to, input logic se);
      return {g1, g2, g1 | g2, g2, g1, sg, to, se};
   endfunction

   task automatic push(input int n, input logic [7:0] s, input logic [9:0] e);
      for (int i = 0; i < n; i++) begin
         stim_q.push_back(s);
         exp_q.push_back(e);
      end
   endtask

   task automatic apply(input logic [7:0] s);
      {m1_req, m1_sel, m1_done, m2_req, m2_sel, m2_done} = s;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      apply(8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [9:0] e;
      #1;
      rst_n = 1'b0;
      apply(8'h00);
      #2;
      tests_run++;
      if (obs !== Z) begin
         tests_failed++;
         $display("FAIL reset_async: got %b want %b", obs, Z);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (obs !== Z) begin
         tests_failed++;
         $display("FAIL reset_held: got %b want %b", obs, Z);
      end
      rst_n = 1'b1;
      // Idle with no requests stays quiet.
      push(2, 8'h00, Z);
      for (int n = 0; stim_q.size() > 0; n++) begin
         apply(stim_q.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         tests_run++;
         if (obs !== e) begin
            tests_failed++;
            $display("FAIL reset_idle cyc%0d: got %b want %b", n, obs, e);
         end
      end
   endtask

   task automatic test_solo();
      logic [9:0] e;
      push(1, st(1, 2'b10, 0, 0, 2'b00, 0), ex(1, 0, 3'b010, 0, 0));  // GRANT
      push(5, st(1, 2'b10, 0, 0, 2'b00, 0), ex(1, 0, 3'b010, 0, 0));  // BUSY
      push(1, st(0, 2'b10, 1, 0, 2'b00, 0), Z);                       // RELEASE
      push(2, 8'h00, Z);
      for (int n = 0; stim_q.size() > 0; n++) begin
         apply(stim_q.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         tests_run++;
         if (obs !== e) begin
            tests_failed++;
            $display("FAIL solo cyc%0d: got %b want %b", n, obs, e);
         end
      end
   endtask

   task automatic test_alternation();
      logic [9:0] e;
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         push(2, st(1, 2'b01, 0, 1, 2'b10, 0), ex(1, 0, 3'b001, 0, 0));
         push(1, st(0, 2'b01, 1, 1, 2'b10, 0), Z);
         push(1, st(0, 2'b00, 0, 1, 2'b10, 0), Z);
         push(2, st(0, 2'b00, 0, 1, 2'b10, 0), ex(0, 1, 3'b010, 0, 0));
         push(1, st(0, 2'b00, 0, 0, 2'b10, 1), Z);
         // Both request again while RELEASE is still in progress.
         if (k == 0) push(1, st(1, 2'b01, 0, 1, 2'b10, 0), Z);
         else push(1, 8'h00, Z);
      end
      for (int n = 0; stim_q.size() > 0; n++) begin
         apply(stim_q.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         tests_run++;
         if (obs !== e) begin
            tests_failed++;
            $display("FAIL alternation cyc%0d: got %b want %b", n, obs, e);
         end
      end
   endtask

   task automatic test_timeout();
      logic [9:0] e;
      push(1, st(0, 2'b00, 0, 1, 2'b11, 0), ex(0, 1, 3'b100, 0, 0));  // GRANT
      push(8, st(1, 2'b10, 0, 1, 2'b11, 0), ex(0, 1, 3'b100, 0, 0));  // BUSY, wdog 0..6
      push(1, st(1, 2'b10, 0, 1, 2'b11, 0), ex(0, 0, 3'b000, 1, 0));  // wdog 7: forced
      push(1, st(1, 2'b10, 0, 1, 2'b11, 0), Z);
      push(1, st(1, 2'b10, 0, 1, 2'b11, 0), ex(1, 0, 3'b010, 0, 0));  // pending M1 wins
      push(1, st(1, 2'b10, 0, 0, 2'b11, 0), ex(1, 0, 3'b010, 0, 0));
      push(1, st(0, 2'b10, 1, 0, 2'b00, 0), Z);
      push(1, 8'h00, Z);
      for (int n = 0; stim_q.size() > 0; n++) begin
         apply(stim_q.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         tests_run++;
         if (obs !== e) begin
            tests_failed++;
            $display("FAIL timeout cyc%0d: got %b want %b", n, obs, e);
         end
      end
   endtask

   task automatic test_sel_error();
      logic [9:0] e;
      apply_reset();
      push(1, st(1, 2'b00, 0, 1, 2'b11, 0), ex(0, 0, 3'b000, 0, 1));  // M1 wins, code 00
      push(1, st(1, 2'b00, 0, 1, 2'b11, 0), ex(0, 1, 3'b100, 0, 0));  // M2's turn
      push(1, st(0, 2'b00, 0, 1, 2'b11, 0), ex(0, 1, 3'b100, 0, 0));
      push(1, st(0, 2'b00, 0, 0, 2'b11, 1), Z);
      push(1, 8'h00, Z);
      push(1, st(1, 2'b00, 0, 0, 2'b00, 0), ex(0, 0, 3'b000, 0, 1));
      push(1, 8'h00, Z);
      for (int n = 0; stim_q.size() > 0; n++) begin
         apply(stim_q.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         tests_run++;
         if (obs !== e) begin
            tests_failed++;
            $display("FAIL sel_error cyc%0d: got %b want %b", n, obs, e);
         end
      end
   endtask

   task automatic test_ignore_and_abort();
      logic [9:0] e;
      push(1, st(1, 2'b01, 0, 0, 2'b00, 0), ex(1, 0, 3'b001, 0, 0));
      push(2, st(1, 2'b11, 0, 0, 2'b00, 1), ex(1, 0, 3'b001, 0, 0));  // foreign done, new sel
      push(1, st(1, 2'b10, 0, 0, 2'b00, 0), ex(1, 0, 3'b001, 0, 0));
      push(1, st(0, 2'b10, 1, 0, 2'b00, 0), Z);
      push(1, 8'h00, Z);
      push(1, st(1, 2'b10, 0, 0, 2'b00, 0), ex(1, 0, 3'b010, 0, 0));
      push(1, st(0, 2'b10, 0, 0, 2'b00, 0), Z);                       // abort in GRANT
      push(2, 8'h00, Z);
      for (int n = 0; stim_q.size() > 0; n++) begin
         apply(stim_q.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         tests_run++;
         if (obs !== e) begin
            tests_failed++;
            $display("FAIL ignore_abort cyc%0d: got %b want %b", n, obs, e);
         end
      end
   endtask

   task automatic test_done_vs_timeout();
      logic [9:0] e;
      push(9, st(1, 2'b01, 0, 0, 2'b00, 0), ex(1, 0, 3'b001, 0, 0));  // GRANT + wdog 0..6
      push(1, st(0, 2'b01, 1, 0, 2'b00, 0), Z);                       // done at wdog 7
      push(1, 8'h00, Z);
      for (int n = 0; stim_q.size() > 0; n++) begin
         apply(stim_q.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         tests_run++;
         if (obs !== e) begin
            tests_failed++;
            $display("FAIL done_vs_timeout cyc%0d: got %b want %b", n, obs, e);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [9:0] e;
      push(3, st(1, 2'b01, 0, 0, 2'b00, 0), ex(1, 0, 3'b001, 0, 0));
      for (int n = 0; stim_q.size() > 0; n++) begin
         apply(stim_q.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         tests_run++;
         if (obs !== e) begin
            tests_failed++;
            $display("FAIL async_pre cyc%0d: got %b want %b", n, obs, e);
         end
      end
      #3;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (obs !== Z) begin
         tests_failed++;
         $display("FAIL async_drop: got %b want %b", obs, Z);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // M1 was served last before reset; it wins only because reset restored the tie rule.
      push(2, st(1, 2'b10, 0, 1, 2'b01, 0), ex(1, 0, 3'b010, 0, 0));
      push(1, st(0, 2'b10, 1, 1, 2'b01, 0), Z);
      push(1, st(0, 2'b00, 0, 0, 2'b01, 0), Z);
      for (int n = 0; stim_q.size() > 0; n++) begin
         apply(stim_q.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         tests_run++;
         if (obs !== e) begin
            tests_failed++;
            $display("FAIL async_post cyc%0d: got %b want %b", n, obs, e);
         end
      end
   endtask

   initial begin
      apply(8'h00);
      test_reset();
      test_solo();
      test_alternation();
      test_timeout();
      test_sel_error();
      test_ignore_and_abort();
      test_done_vs_timeout();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
